// File: rtl/dmem_ctrl.sv
// Data-memory stage: byte/half/word loads and stores over a word array with a
// req/ready + rsp_valid handshake, error flagging and saturating access counters.
module dmem_ctrl #(
    parameter int          DEPTH = 1024,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt_load,
    output logic [CNT_W-1:0] cnt_store,
    output logic [CNT_W-1:0] cnt_err
);

    // state  | meaning
    // IDLE   | ready for a request
    // BUSY   | latched request: check errors, write lanes or read word
    // RESP   | rsp_valid pulse with result, then back to IDLE
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] data_mem [0:DEPTH-1];

    logic [29:0]   widx;
    logic [AW-1:0] idx;
    logic          oor;
    logic          err;
    logic [31:0]   rword;
    logic [31:0]   bsh;
    logic [31:0]   hsh;
    logic [31:0]   ldata;
    logic [3:0]    be;
    logic [31:0]   wd;

    assign req_ready = (state == S_IDLE) && !rst;

    // Word index relative to BASE; addresses below BASE wrap high and read as out of range.
    assign widx = addr_q[31:2] - BASE[31:2];
    assign idx  = widx[AW-1:0];
    assign oor  = {2'b00, widx} >= 32'(DEPTH);

    assign rword = data_mem[idx];
    assign bsh   = rword >> {addr_q[1:0], 3'b000};
    assign hsh   = rword >> {addr_q[1], 4'b0000};

    always_comb begin
        err = oor;
        case (size_q)
            2'd1:    err = oor | addr_q[0];
            2'd2:    err = oor | (addr_q[1:0] != 2'b00);
            2'd3:    err = 1'b1;
            default: err = oor;
        endcase
    end

    always_comb begin
        ldata = rword;
        be    = 4'b1111;
        wd    = wdata_q;
        case (size_q)
            2'd0: begin
                ldata = uns_q ? {24'h0, bsh[7:0]} : {{24{bsh[7]}}, bsh[7:0]};
                be    = 4'b0001 << addr_q[1:0];
                wd    = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                ldata = uns_q ? {16'h0, hsh[15:0]} : {{16{hsh[15]}}, hsh[15:0]};
                be    = addr_q[1] ? 4'b1100 : 4'b0011;
                wd    = {2{wdata_q[15:0]}};
            end
            default: begin
                ldata = rword;
                be    = 4'b1111;
                wd    = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            cnt_load  <= '0;
            cnt_store <= '0;
            cnt_err   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    rsp_rdata <= (err || we_q) ? 32'h0 : ldata;
                    if (err) begin
                        if (cnt_err != {CNT_W{1'b1}}) cnt_err <= cnt_err + 1'b1;
                    end else if (we_q) begin
                        if (cnt_store != {CNT_W{1'b1}}) cnt_store <= cnt_store + 1'b1;
                    end else begin
                        if (cnt_load != {CNT_W{1'b1}}) cnt_load <= cnt_load + 1'b1;
                    end
                    state <= S_RESP;
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; a reset in BUSY suppresses the write.
    always_ff @(posedge clk) begin
        if (state == S_BUSY && we_q && !err && !rst) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) data_mem[idx][8*k +: 8] <= wd[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: table of load/store vectors plus hand-written
// sequences for back-to-back requests and reset during BUSY.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] cnt_load;
    logic [15:0] cnt_store;
    logic [15:0] cnt_err;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    dmem_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_err(cnt_err)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic xact(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) check({name, " ready_timeout"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        check({name, " busy_no_rsp"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          exp_ld, exp_st, exp_er;

        vecs.push_back('{"sw0",      1, 2, 0, 32'h0, 32'h12345678, 32'h0,        0});
        vecs.push_back('{"lw0",      0, 2, 0, 32'h0, 32'h0,        32'h12345678, 0});
        vecs.push_back('{"lb1",      0, 0, 0, 32'h1, 32'h0,        32'h00000056, 0});
        vecs.push_back('{"lbu3",     0, 0, 1, 32'h3, 32'h0,        32'h00000012, 0});
        vecs.push_back('{"lh2",      0, 1, 0, 32'h2, 32'h0,        32'h00001234, 0});
        vecs.push_back('{"lhu0",     0, 1, 1, 32'h0, 32'h0,        32'h00005678, 0});
        vecs.push_back('{"sw4_clr",  1, 2, 0, 32'h4, 32'h0,        32'h0,        0});
        vecs.push_back('{"sb4",      1, 0, 0, 32'h4, 32'hAAAAAA80, 32'h0,        0});
        vecs.push_back('{"lw4_a",    0, 2, 0, 32'h4, 32'h0,        32'h00000080, 0});
        vecs.push_back('{"lb4",      0, 0, 0, 32'h4, 32'h0,        32'hFFFFFF80, 0});
        vecs.push_back('{"lbu4",     0, 0, 1, 32'h4, 32'h0,        32'h00000080, 0});
        vecs.push_back('{"sh6",      1, 1, 0, 32'h6, 32'h5555BEEF, 32'h0,        0});
        vecs.push_back('{"lw4_b",    0, 2, 0, 32'h4, 32'h0,        32'hBEEF0080, 0});
        vecs.push_back('{"lh6",      0, 1, 0, 32'h6, 32'h0,        32'hFFFFBEEF, 0});
        vecs.push_back('{"lhu6",     0, 1, 1, 32'h6, 32'h0,        32'h0000BEEF, 0});
        vecs.push_back('{"sh5_err",  1, 1, 0, 32'h5, 32'h00001111, 32'h0,        1});
        vecs.push_back('{"sw2_err",  1, 2, 0, 32'h2, 32'h22222222, 32'h0,        1});
        vecs.push_back('{"sz3_err",  0, 3, 0, 32'h0, 32'h0,        32'h0,        1});
        vecs.push_back('{"oor_err",  0, 2, 0, 32'h1000, 32'h0,     32'h0,        1});
        vecs.push_back('{"lw0_keep", 0, 2, 0, 32'h0, 32'h0,        32'h12345678, 0});
        vecs.push_back('{"lw4_keep", 0, 2, 0, 32'h4, 32'h0,        32'hBEEF0080, 0});
        vecs.push_back('{"sb3",      1, 0, 0, 32'h3, 32'h0000007F, 32'h0,        0});
        vecs.push_back('{"lh2_b",    0, 1, 0, 32'h2, 32'h0,        32'h00007F34, 0});
        vecs.push_back('{"lw0_b",    0, 2, 0, 32'h0, 32'h0,        32'h7F345678, 0});
        vecs.push_back('{"sw8_pre",  1, 2, 0, 32'h8, 32'h11111111, 32'h0,        0});

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'h0);
        check("rst rsp_err",   32'(rsp_err), 32'd0);
        check("rst cnt_load",  32'(cnt_load), 32'd0);
        check("rst cnt_store", 32'(cnt_store), 32'd0);
        check("rst cnt_err",   32'(cnt_err), 32'd0);
        rst = 1'b0;

        exp_ld = 0; exp_st = 0; exp_er = 0;
        foreach (vecs[i]) begin
            xact(vecs[i].name, vecs[i].we, vecs[i].size, vecs[i].uns,
                 vecs[i].addr, vecs[i].wdata, rd, er);
            check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
            if (vecs[i].exp_err) exp_er++;
            else if (vecs[i].we) exp_st++;
            else exp_ld++;
        end
        @(negedge clk);
        check("hold rdata after pulse", rsp_rdata, 32'h0);
        check("tbl cnt_load",  32'(cnt_load), 32'(exp_ld));
        check("tbl cnt_store", 32'(cnt_store), 32'(exp_st));
        check("tbl cnt_err",   32'(cnt_err), 32'(exp_er));

        // Back-to-back: req_valid held high for 10 cycles, accepted only in IDLE.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'hCAFEF00D;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("b2b ready c%0d", c), 32'(req_ready), 32'((c % 3) == 0));
            check($sformatf("b2b rsp c%0d", c), 32'(rsp_valid), 32'((c % 3) == 2));
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        exp_st += 4;
        check("b2b cnt_store", 32'(cnt_store), 32'(exp_st));
        xact("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er);
        check("lw10 rdata", rd, 32'hCAFEF00D);

        // Reset in BUSY aborts the store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
        req_addr = 32'h8; req_wdata = 32'hDEADBEEF;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort ready",     32'(req_ready), 32'd1);
        check("abort rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort cnt_load",  32'(cnt_load), 32'd0);
        check("abort cnt_store", 32'(cnt_store), 32'd0);
        check("abort cnt_err",   32'(cnt_err), 32'd0);
        @(negedge clk);
        check("abort rsp_valid2", 32'(rsp_valid), 32'd0);
        xact("lw8", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, rd, er);
        check("lw8 rdata", rd, 32'h11111111);
        check("lw8 err",   32'(er), 32'd0);
        @(negedge clk);
        check("post cnt_load", 32'(cnt_load), 32'd1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
